// File: rtl/riscv_dbg_dump.sv
// Post-run state dump: walks the register file, then an optional data-memory window,
// onto a valid/ready stream. Define DBG_DUMP_MEM_EN to include the memory phase.
module riscv_dbg_dump #(
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] dm_raddr,
    input  logic [31:0] dm_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_tag,
    output logic [7:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REG   = 3'd1,
        ST_MEM   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);
`ifdef DBG_DUMP_MEM_EN
    localparam logic [7:0] MEM_LAST = 8'(MEM_WORDS - 1);
`else
    logic unused_s;
    assign unused_s = ^{dm_rdata, MEM_BASE, (MEM_WORDS > 0)};
`endif

    state_t      state_r;
    logic [7:0]  idx_r;
    logic        debug_q_r;
    logic [4:0]  rf_raddr_r;
    logic [31:0] dm_raddr_r;
    logic        out_valid_r;
    logic        out_tag_r;
    logic [7:0]  out_idx_r;
    logic [31:0] out_data_r;
    logic        busy_r;
    logic        done_r;

    logic start_s;
    logic slot_free_s;
    logic accept_s;

    assign start_s     = debug & ~debug_q_r & (state_r == ST_IDLE);
    assign slot_free_s = ~out_valid_r | out_ready;
    assign accept_s    = out_valid_r & out_ready;

    // Read addresses are kept as registers advancing in step with idx_r,
    // so the read data they select is ready at the capturing edge.
    // Dump sequencer, output staging register and read-address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 8'd0;
            debug_q_r   <= 1'b0;
            rf_raddr_r  <= 5'd0;
            dm_raddr_r  <= 32'd0;
            out_valid_r <= 1'b0;
            out_tag_r   <= 1'b0;
            out_idx_r   <= 8'd0;
            out_data_r  <= 32'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            debug_q_r <= debug;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_REG;
                        idx_r      <= 8'd0;
                        rf_raddr_r <= 5'd0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_REG: begin
                    if (slot_free_s) begin
                        out_valid_r <= 1'b1;
                        out_tag_r   <= 1'b0;
                        out_idx_r   <= idx_r;
                        out_data_r  <= rf_rdata;
                        if (idx_r == REG_LAST) begin
                            idx_r      <= 8'd0;
                            rf_raddr_r <= 5'd0;
`ifdef DBG_DUMP_MEM_EN
                            state_r    <= ST_MEM;
                            dm_raddr_r <= MEM_BASE;
`else
                            state_r    <= ST_DRAIN;
`endif
                        end else begin
                            idx_r      <= idx_r + 8'd1;
                            rf_raddr_r <= rf_raddr_r + 5'd1;
                        end
                    end
                end
`ifdef DBG_DUMP_MEM_EN
                ST_MEM: begin
                    if (slot_free_s) begin
                        out_valid_r <= 1'b1;
                        out_tag_r   <= 1'b1;
                        out_idx_r   <= idx_r;
                        out_data_r  <= dm_rdata;
                        if (idx_r == MEM_LAST) begin
                            idx_r      <= 8'd0;
                            dm_raddr_r <= 32'd0;
                            state_r    <= ST_DRAIN;
                        end else begin
                            idx_r      <= idx_r + 8'd1;
                            dm_raddr_r <= dm_raddr_r + 32'd4;
                        end
                    end
                end
`endif
                ST_DRAIN: begin
                    if (accept_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign rf_raddr  = rf_raddr_r;
    assign dm_raddr  = dm_raddr_r;
    assign out_valid = out_valid_r;
    assign out_tag   = out_tag_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/riscv_dbg_dump.md
# riscv_dbg_dump

Post-run state dump unit sitting downstream of the single-cycle RISC-V top. On a rising edge of the `debug` strobe it walks the architectural register file, then an optional window of data memory, through dedicated read ports. Each word is emitted on a valid/ready output stream tagged with its source and index, so a bench or host-side logger can capture final machine state without hierarchical peeking.

## Interface
- `REG_COUNT`, 32: registers dumped, x0..x(REG_COUNT-1); must be 1..32.
- `MEM_BASE`, 32'h0000_0000: byte address of the first data-memory word dumped; word-aligned.
- `MEM_WORDS`, 16: data-memory words dumped; must be 1..256.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `debug` input 1: dump trigger; rising edge detected synchronously.
- `rf_raddr` output 5: register-file read address.
- `rf_rdata` input 32: register-file read data; combinational from `rf_raddr`, same cycle.
- `dm_raddr` output 32: data-memory byte read address.
- `dm_rdata` input 32: data-memory read data; combinational from `dm_raddr`, same cycle.
- `out_valid` output 1: output word valid.
- `out_ready` input 1: consumer accepts the word when high with `out_valid`.
- `out_tag` output 1: 0 = register word, 1 = memory word.
- `out_idx` output 8: register number or memory word index.
- `out_data` output 32: dumped word.
- `busy` output 1: high from trigger until `done`.
- `done` output 1: one-cycle pulse after the final word is accepted.

## Operation
- Edge detection: `debug_q` registers `debug`; start = `debug & ~debug_q`, qualified by state IDLE. Triggers in any other state are ignored. A held-high `debug` triggers once.
- States:
  - IDLE: start -> REG, with `idx`=0.
  - REG: `rf_raddr`=`idx[4:0]`. The slot is free when `!out_valid || out_ready`. When the slot is free, capture `rf_rdata` into `out_data`, set `out_valid`=1, `out_tag`=0, `out_idx`=`idx`, and increment `idx`. Capture of index REG_COUNT-1 -> MEM with `idx`=0.
  - MEM: `dm_raddr`=`MEM_BASE + {idx,2'b00}` (32-bit add, wraps modulo 2^32). Captures work as in REG, with `out_tag`=1. Capture of index MEM_WORDS-1 -> DRAIN.
  - DRAIN: wait for `out_valid && out_ready`, then -> DONE.
  - DONE: `done`=1 for one cycle -> IDLE.
- Outside their active state, `rf_raddr` and `dm_raddr` are 0.
- `out_valid` drops on acceptance when no new capture occurs in the same cycle.
- While `out_valid && !out_ready`, `out_data`, `out_tag` and `out_idx` hold stable.
- x0 is dumped as read; no forced zero.
- `busy` = (state != IDLE).
- `idx` is 8 bits and never exceeds count-1.

## Timing
- Reset value of every output: `out_valid`=0, `out_tag`=0, `out_idx`=0, `out_data`=0, `busy`=0, `done`=0, `rf_raddr`=0, `dm_raddr`=0. State is IDLE and `debug_q`=0.
- Reset applies immediately, asynchronously, including mid-dump. An in-flight word is discarded. The next trigger restarts at x0.
- Edge E0: `debug` first sampled high -> state REG at E0. First `out_valid` rises at E1.
- Throughput with `out_ready` held high: one word per cycle, with no bubble between the REG and MEM phases.
- `done` is asserted the cycle after the final word is accepted. `busy` falls together with `done`'s deassertion.
- Total with `out_ready`=1: REG_COUNT+MEM_WORDS beats on consecutive cycles, then one DRAIN cycle, then the `done` cycle.

## Configuration
- `DBG_DUMP_MEM_EN` defined: the MEM phase is included as above.
- Not defined: the MEM phase is removed. Capture of the last register goes to DRAIN, `dm_raddr` is tied to 0, `dm_rdata` is unused, and `out_tag` is always 0.

## Test plan
- Reset: hold `rst`=0 for 3 cycles -> all outputs 0 and `busy`=0. Assert `rst` mid-dump (at beat 10) -> `out_valid` and `busy` go 0 without waiting for a clock edge.
- Full dump with `DBG_DUMP_MEM_EN` defined, `out_ready`=1, register xi = i*3, mem[MEM_BASE+4k] = 32'hA000_0000+k:
  - 32 consecutive beats, tag 0, idx 0..31, data 0..93;
  - then 16 beats, tag 1, idx 0..15, data A000_0000..A000_000F;
  - then one `done` pulse.
- Backpressure: `out_ready` toggles 1,0,0,1,... -> every beat is accepted exactly once and in order. Payload is stable during every stall, and the word count is still 48.
- Retrigger: `debug` held high for 10 cycles, then re-pulsed at beat 20 -> exactly one dump of 48 words, with no restart.
- Macro off, `REG_COUNT`=8: one pulse -> 8 beats, tag 0, `dm_raddr` stays 0, then `done`.
- Address wrap: `MEM_BASE`=32'hFFFF_FFF8, `MEM_WORDS`=4 -> `dm_raddr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
